axis_spi_burst_ctrl: RTL and testbench

Register-burst sequencer placed directly upstream of `axis_spi_master`. It accepts a command, sends a header byte followed by N data bytes (write data or dummy fill) into the master's `s_axis`, and tracks selected-slave address. It also consumes every byte returned on the master's `m_axis`, discarding header and write echoes and forwarding read bytes to the user with `tlast` on the final byte.

---
 rtl/axis_spi_pkg.sv | 32 +++
 rtl/axis_if.sv | 12 +
 rtl/axis_spi_burst_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_axis_spi_burst_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_spi_pkg.sv
// Shared types for the SPI register-burst sequencer: FSM states, latched command, header packing.
package axis_spi_pkg;

  localparam int unsigned MAX_DW = 32;
  localparam int unsigned MAX_LW = 16;
  localparam int unsigned MAX_AW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } burst_state_t;

  // Fields sized for the largest supported build; narrower builds zero-extend into them.
  typedef struct packed {
    logic              rw;
    logic [MAX_DW-2:0] reg_addr;
    logic [MAX_LW-1:0] len;
    logic [MAX_AW-1:0] slave;
  } burst_cmd_t;

  function automatic logic [MAX_DW-1:0] pack_hdr(input logic rw,
                                                 input logic [MAX_DW-2:0] reg_addr,
                                                 input int unsigned dw);
    logic [MAX_DW-1:0] hdr;
    hdr = {1'b0, reg_addr};
    hdr[dw-1] = rw;
    return hdr;
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle used between the sequencer, the user and the SPI master.
interface axis_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_spi_burst_ctrl.sv
// Register-burst sequencer in front of axis_spi_master: header + N data bytes out, read bytes back.
// Optional drain watchdog enabled by defining AXIS_SPI_BURST_WDOG_EN.
module axis_spi_burst_ctrl
  import axis_spi_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           LEN_WIDTH      = 8,
  parameter int unsigned           SLAVE_NUM      = 1,
  parameter logic [DATA_WIDTH-1:0] DUMMY_BYTE     = 8'h00,
  parameter int unsigned           TIMEOUT_CYCLES = 4096,
  localparam int unsigned          AW             = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_rw_i,
  input  logic [DATA_WIDTH-2:0] cmd_reg_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [AW-1:0]         cmd_slave_i,
  output logic [AW-1:0]         addr_o,
  output logic                  busy_o,
  output logic                  err_o,
  axis_if.slave                 s_axis,
  axis_if.master                m_axis,
  axis_if.master                spi_tx,
  axis_if.slave                 spi_rx
);

  burst_state_t           state_r;
  burst_cmd_t             cmd_r;
  burst_cmd_t             cmd_s;
  logic [LEN_WIDTH-1:0]   tx_cnt_r;
  logic [LEN_WIDTH:0]     rx_cnt_r;
  logic [LEN_WIDTH-1:0]   len_s;
  logic [LEN_WIDTH-1:0]   len_m1_s;
  logic [LEN_WIDTH:0]     len_p1_s;
  logic [MAX_DW-1:0]      hdr_full_s;
  logic [DATA_WIDTH-1:0]  hdr_s;
  logic                   tx_hs_s;
  logic                   rx_hs_s;
  logic                   rx_pass_s;
  logic                   rx_cnt_en_s;
  logic                   rx_fin_s;
  logic                   rx_done_s;
  logic                   timeout_s;

  // Zero-extend the incoming command into the package-wide struct.
  always_comb begin
    cmd_s                         = '0;
    cmd_s.rw                      = cmd_rw_i;
    cmd_s.reg_addr[DATA_WIDTH-2:0] = cmd_reg_i;
    cmd_s.len[LEN_WIDTH-1:0]      = cmd_len_i;
    cmd_s.slave[AW-1:0]           = cmd_slave_i;
  end

  assign len_s      = cmd_r.len[LEN_WIDTH-1:0];
  assign len_m1_s   = len_s - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  assign len_p1_s   = {1'b0, len_s} + {{LEN_WIDTH{1'b0}}, 1'b1};
  assign hdr_full_s = pack_hdr(cmd_r.rw, cmd_r.reg_addr, DATA_WIDTH);
  assign hdr_s      = hdr_full_s[DATA_WIDTH-1:0];

  assign cmd_ready_o = (state_r == IDLE);
  assign busy_o      = (state_r != IDLE);
  assign addr_o      = cmd_r.slave[AW-1:0];

  assign tx_hs_s = spi_tx.tvalid && spi_tx.tready;
  assign rx_hs_s = spi_rx.tvalid && spi_rx.tready;

  // Once len+1 echoes are in, further rx bytes are dropped without advancing the count.
  assign rx_done_s   = (rx_cnt_r == len_p1_s);
  assign rx_cnt_en_s = rx_hs_s && (state_r != IDLE) && !rx_done_s;
  assign rx_fin_s    = rx_cnt_en_s && (rx_cnt_r == {1'b0, len_s});
  assign rx_pass_s   = (state_r != IDLE) && cmd_r.rw && (rx_cnt_r != '0) &&
                       (rx_cnt_r <= {1'b0, len_s});

  // Transmit mux: header, then either user write data or dummy fill for reads.
  always_comb begin
    spi_tx.tvalid = 1'b0;
    spi_tx.tdata  = '0;
    spi_tx.tlast  = 1'b0;
    s_axis.tready = 1'b0;
    case (state_r)
      HDR: begin
        spi_tx.tvalid = 1'b1;
        spi_tx.tdata  = hdr_s;
        spi_tx.tlast  = (len_s == '0);
      end
      DATA: begin
        spi_tx.tlast = (tx_cnt_r == len_m1_s);
        if (cmd_r.rw) begin
          spi_tx.tvalid = 1'b1;
          spi_tx.tdata  = DUMMY_BYTE;
        end else begin
          spi_tx.tvalid = s_axis.tvalid;
          spi_tx.tdata  = s_axis.tdata;
          s_axis.tready = spi_tx.tready;
        end
      end
      default: begin
        spi_tx.tvalid = 1'b0;
      end
    endcase
  end

  // Receive path: read data bytes pass through, everything else is swallowed.
  always_comb begin
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = spi_rx.tdata;
    m_axis.tlast  = 1'b0;
    spi_rx.tready = 1'b1;
    if (rx_pass_s) begin
      m_axis.tvalid = spi_rx.tvalid;
      m_axis.tlast  = (rx_cnt_r == {1'b0, len_s});
      spi_rx.tready = m_axis.tready;
    end else begin
      spi_rx.tready = 1'b1;
    end
  end

  // Burst FSM with command latch and tx/rx byte counters.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_r  <= IDLE;
      cmd_r    <= '0;
      tx_cnt_r <= '0;
      rx_cnt_r <= '0;
    end else begin
      if (rx_cnt_en_s) begin
        rx_cnt_r <= rx_cnt_r + {{LEN_WIDTH{1'b0}}, 1'b1};
      end
      case (state_r)
        IDLE: begin
          if (cmd_valid_i) begin
            cmd_r    <= cmd_s;
            tx_cnt_r <= '0;
            rx_cnt_r <= '0;
            state_r  <= HDR;
          end
        end
        HDR: begin
          if (tx_hs_s) begin
            state_r <= (len_s == '0) ? DRAIN : DATA;
          end
        end
        DATA: begin
          if (tx_hs_s) begin
            tx_cnt_r <= tx_cnt_r + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
            if (tx_cnt_r == len_m1_s) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (rx_done_s || rx_fin_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      if (timeout_s) begin
        state_r <= IDLE;
      end
    end
  end

`ifdef AXIS_SPI_BURST_WDOG_EN
  logic [31:0] wdog_cnt_r;
  logic        err_r;

  assign timeout_s = ((state_r == DATA) || (state_r == DRAIN)) &&
                     (wdog_cnt_r == 32'(TIMEOUT_CYCLES - 1));
  assign err_o     = err_r;

  // Idle-link watchdog: any tx or rx handshake restarts the count.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wdog_cnt_r <= 32'd0;
      err_r      <= 1'b0;
    end else begin
      err_r <= timeout_s;
      if (((state_r == DATA) || (state_r == DRAIN)) && !tx_hs_s && !rx_hs_s && !timeout_s) begin
        wdog_cnt_r <= wdog_cnt_r + 32'd1;
      end else begin
        wdog_cnt_r <= 32'd0;
      end
    end
  end
`else
  assign timeout_s = 1'b0;
  assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_axis_spi_burst_ctrl.sv
// Scoreboard bench: stimulus queues expected spi_tx / m_axis bytes, a negedge monitor pops and compares.
module tb_axis_spi_burst_ctrl;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int SN = 4;
  localparam int AW = 2;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_rw = 1'b0;
  logic [DW-2:0] cmd_reg = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [AW-1:0] cmd_slave = '0;
  logic [AW-1:0] addr;
  logic          busy;
  logic          err;

  axis_if #(.DATA_WIDTH(DW)) s_axis ();
  axis_if #(.DATA_WIDTH(DW)) m_axis ();
  axis_if #(.DATA_WIDTH(DW)) spi_tx ();
  axis_if #(.DATA_WIDTH(DW)) spi_rx ();

  axis_spi_burst_ctrl #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .SLAVE_NUM(SN),
    .DUMMY_BYTE(8'h00), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .arstn_i(arstn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_rw_i(cmd_rw), .cmd_reg_i(cmd_reg), .cmd_len_i(cmd_len), .cmd_slave_i(cmd_slave),
    .addr_o(addr), .busy_o(busy), .err_o(err),
    .s_axis(s_axis), .m_axis(m_axis), .spi_tx(spi_tx), .spi_rx(spi_rx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_tx_q[$];
  logic [8:0] exp_m_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] slave_q[$];
  logic [7:0] rx_pend[$];
  int tx_hs_cnt = 0;
  int rx_hs_cnt = 0;
  bit tx_rand = 1'b0;
  bit m_rand = 1'b0;
  bit rx_hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake on spi_tx / m_axis is matched against the scoreboard.
  always @(negedge clk) begin
    if (arstn) begin
      if (spi_tx.tvalid && spi_tx.tready) begin
        if (exp_tx_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_extra: got %0h expected none", spi_tx.tdata);
        end else begin
          check("tx_byte", 32'(spi_tx.tdata), 32'(exp_tx_q.pop_front()));
        end
      end
      if (m_axis.tvalid && (exp_m_q.size() == 0)) begin
        total++; bad++;
        $display("FAIL m_unexpected: got %0h last=%0b expected silence", m_axis.tdata, m_axis.tlast);
      end else if (m_axis.tvalid && m_axis.tready) begin
        check("m_byte_last", 32'({m_axis.tlast, m_axis.tdata}), 32'(exp_m_q.pop_front()));
      end
    end
  end

  // SPI master / slave loopback model plus user-side write source.
  initial begin
    bit txh, rxh, sh;
    spi_tx.tready = 1'b0; spi_rx.tvalid = 1'b0; spi_rx.tdata = '0; spi_rx.tlast = 1'b0;
    m_axis.tready = 1'b0; s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tlast = 1'b0;
    forever begin
      @(negedge clk);
      txh = arstn && spi_tx.tvalid && spi_tx.tready;
      rxh = arstn && spi_rx.tvalid && spi_rx.tready;
      sh  = arstn && s_axis.tvalid && s_axis.tready;
      @(posedge clk);
      #1;
      if (arstn) begin
        if (rxh) begin rx_hs_cnt++; void'(rx_pend.pop_front()); end
        if (txh) begin
          tx_hs_cnt++;
          rx_pend.push_back((slave_q.size() > 0) ? slave_q.pop_front() : 8'hFF);
        end
        if (sh) void'(wr_q.pop_front());
      end
      spi_tx.tready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axis.tready = m_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      spi_rx.tvalid = !rx_hold && (rx_pend.size() > 0);
      spi_rx.tdata  = (rx_pend.size() > 0) ? rx_pend[0] : 8'h00;
      s_axis.tvalid = (wr_q.size() > 0);
      s_axis.tdata  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
    end
  end

  task automatic issue(input logic rw, input logic [6:0] rg, input int len,
                       input logic [AW-1:0] sl, input logic [7:0] data[$]);
    int n;
    exp_tx_q.push_back({rw, rg});
    slave_q.push_back(8'hEE);
    for (int i = 0; i < len; i++) begin
      if (rw) begin
        exp_tx_q.push_back(8'h00);
        slave_q.push_back(data[i]);
        exp_m_q.push_back({(i == len - 1), data[i]});
      end else begin
        exp_tx_q.push_back(data[i]);
        wr_q.push_back(data[i]);
        slave_q.push_back(8'hE0 + 8'(i));
      end
    end
    @(posedge clk); #1;
    cmd_rw = rw; cmd_reg = rg; cmd_len = 8'(len); cmd_slave = sl; cmd_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 50);
    if (!cmd_ready) begin total++; bad++; $display("FAIL cmd_accept: got ready=0 expected 1"); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("hdr_latency", 32'(spi_tx.tvalid), 32'd1);
    check("addr_held", 32'(addr), 32'(sl));
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin @(negedge clk); n++; end
    if (busy) begin total++; bad++; $display("FAIL %s_timeout: got busy=1 expected 0", name); end
  endtask

  task automatic finish_check(input string name, input int rx_base, input int nrx, input logic [AW-1:0] sl);
    check({name, "_ready"}, 32'(cmd_ready), 32'd1);
    check({name, "_rx_count"}, 32'(rx_hs_cnt - rx_base), 32'(nrx));
    check({name, "_tx_left"}, 32'(exp_tx_q.size()), 32'd0);
    check({name, "_m_left"}, 32'(exp_m_q.size()), 32'd0);
    check({name, "_addr"}, 32'(addr), 32'(sl));
  endtask

  task automatic flush();
    exp_tx_q.delete(); exp_m_q.delete(); wr_q.delete(); slave_q.delete(); rx_pend.delete();
  endtask

  initial begin
    logic [7:0] d[$];
    int base, tbase, n;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_tx_valid", 32'(spi_tx.tvalid), 32'd0);
    check("rst_m_valid", 32'(m_axis.tvalid), 32'd0);
    check("rst_s_ready", 32'(s_axis.tready), 32'd0);
    check("rst_rx_ready", 32'(spi_rx.tready), 32'd1);
    #20 arstn = 1'b1;

    // write 0x12, len 3 -> 12 A1 B2 C3, nothing on m_axis
    base = rx_hs_cnt; d = '{8'hA1, 8'hB2, 8'hC3};
    issue(1'b0, 7'h12, 3, 2'd0, d);
    wait_idle("wr3", 300); finish_check("wr3", base, 4, 2'd0);

    // read 0x05, len 2 -> 85 00 00, m_axis 5A then 6B+last
    base = rx_hs_cnt; d = '{8'h5A, 8'h6B};
    issue(1'b1, 7'h05, 2, 2'd2, d);
    wait_idle("rd2", 300); finish_check("rd2", base, 3, 2'd2);

    // header-only write
    base = rx_hs_cnt; d.delete();
    issue(1'b0, 7'h12, 0, 2'd1, d);
    wait_idle("hdr_only", 300); finish_check("hdr_only", base, 1, 2'd1);

    // read 0x33, len 4 with random back-pressure on both links
    tx_rand = 1'b1; m_rand = 1'b1;
    base = rx_hs_cnt; d = '{8'h11, 8'h22, 8'h33, 8'h44};
    issue(1'b1, 7'h33, 4, 2'd3, d);
    wait_idle("rd4_bp", 1000); finish_check("rd4_bp", base, 5, 2'd3);
    tx_rand = 1'b0; m_rand = 1'b0;

    // reset after the 2nd data byte of a read
    tbase = tx_hs_cnt; d = '{8'h91, 8'h92, 8'h93, 8'h94};
    issue(1'b1, 7'h40, 4, 2'd1, d);
    n = 0;
    while (tx_hs_cnt < tbase + 3 && n < 200) begin @(posedge clk); #2; n++; end
    check("rst_wait_tx", 32'(tx_hs_cnt - tbase), 32'd3);
    arstn = 1'b0;
    flush();
    spi_rx.tvalid = 1'b0;
    #1;
    check("midrst_tx_valid", 32'(spi_tx.tvalid), 32'd0);
    check("midrst_m_valid", 32'(m_axis.tvalid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_addr", 32'(addr), 32'd0);
    @(posedge clk); #2;
    arstn = 1'b1;

    // command after reset: write 0x2A, len 2
    base = rx_hs_cnt; d = '{8'h5C, 8'h6D};
    issue(1'b0, 7'h2A, 2, 2'd3, d);
    wait_idle("post_rst", 300); finish_check("post_rst", base, 3, 2'd3);

`ifdef AXIS_SPI_BURST_WDOG_EN
    rx_hold = 1'b1; d.delete();
    issue(1'b0, 7'h12, 0, 2'd2, d);
    n = 0;
    while (!err && n < TO + 50) begin @(negedge clk); n++; end
    check("wdog_err", 32'(err), 32'd1);
    check("wdog_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("wdog_pulse_width", 32'(err), 32'd0);
    rx_hold = 1'b0;
    flush();
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
